mag_pulse_seq: RTL and testbench
================================

Name: mag_pulse_seq

Overview:
- Cook sequencer that drives the set/reset inputs of the magnetron SR latch.
- Converts user start/clear commands, door state and a 1 Hz tick into single-cycle S and R pulses.
- Counts down the loaded cook time while cooking.
- Sits between the keypad/timer front end and the SR latch that holds mag_on.

Parameters:
TIME_W, 8, width of cook-time counter in seconds
BEEP_TICKS, 3, tick count of beep after completion (only with MAG_SEQ_BEEP_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
load  input  1  load cook time (single-cycle strobe)
load_time  input  TIME_W  seconds to load
start  input  1  start/resume request (strobe)
clear  input  1  abort and zero the timer (strobe)
door_closed  input  1  1 = door closed (pre-synchronised, level)
tick  input  1  1 Hz enable strobe, one clk wide
S  output  1  set pulse to SR latch (magnetron on)
R  output  1  reset pulse to SR latch (magnetron off)
cooking  output  1  1 while in COOKING
done  output  1  one-cycle pulse on timer expiry
time_left  output  TIME_W  remaining seconds
beep  output  1  completion beep (only with MAG_SEQ_BEEP_EN; else tied 0)

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low. All outputs are registered.
- Reset values:
  - state = INIT; time_left = 0.
  - S = 0, R = 0, cooking = 0, done = 0, beep = 0.
- States: INIT, IDLE, ARMED, COOKING, PAUSED, DONE.
- INIT:
  - Entered only by reset.
  - On the first clk after reset release, assert R for exactly one cycle (forces the latch off), then go to IDLE.
- Command priority each cycle: clear > door open > load > start > tick.
- clear, any state except INIT:
  - time_left <= 0; go to IDLE.
  - Pulse R for one cycle if the state was COOKING.
- load, in IDLE/ARMED/DONE:
  - time_left <= load_time.
  - Next state is ARMED if load_time != 0, else IDLE.
  - Ignored in COOKING and PAUSED.
- start:
  - Accepted in ARMED or PAUSED only, and only with door_closed = 1 and time_left != 0.
  - On accept: go to COOKING and pulse S for one cycle. S rises the cycle after start is sampled.
  - Otherwise ignored, with no pulse.
- COOKING, with priority:
  - door_closed = 0: pulse R, go to PAUSED. A tick in the same cycle is discarded and time_left is not decremented.
  - Else tick with time_left > 1: decrement time_left.
  - Else tick with time_left == 1: time_left <= 0, pulse R and done in the same cycle, go to DONE.
- cooking = 1 exactly while state = COOKING.
- DONE:
  - Holds until load or clear.
  - start is ignored because time_left = 0.
- Invariants:
  - S and R are never both 1.
  - S and R are never high two consecutive cycles.
  - Each S pulse is matched by exactly one later R pulse before the next S pulse.
- Reset asserted mid-COOKING: outputs clear immediately (asynchronously); the INIT R pulse follows on release.
- tick while not COOKING: no effect on time_left.

Optional Feature:
- Macro MAG_SEQ_BEEP_EN.
- Defined:
  - beep goes to 1 on the cycle done pulses.
  - beep stays 1 for BEEP_TICKS tick strobes, then returns to 0.
  - clear, load or reset drops beep to 0 immediately.
- Undefined: beep is a constant 0 and the beep counter logic is absent.

Decomposition:
- Package mag_seq_pkg holds:
  - state encoding constants (3-bit) for INIT/IDLE/ARMED/COOKING/PAUSED/DONE;
  - the TIME_W default.
- One sub-module, mag_seq_timer: a loadable down-counter with tick enable, a zero flag and a one flag.
- The FSM and pulse generation stay in the top module.

Test Plan:
1. Reset release → exactly one R pulse in the first cycle, then IDLE. S = 0, time_left = 0.
2. load_time = 3, start with door closed → S pulse the next cycle and cooking = 1. Three ticks give time_left 2, 1, 0; R and done pulse together on the third tick; cooking = 0.
3. Cooking with time_left = 5, door opens on the same cycle as a tick → R pulse, PAUSED, time_left stays 5. Door closes, start → S pulse, resume from 5.
4. start with door_closed = 0 in ARMED, or start in IDLE with time_left = 0 → no S, state unchanged.
5. Cooking with time_left = 4, clear and start in the same cycle → R pulse, IDLE, time_left = 0, no S. Then load during COOKING is ignored.
6. With MAG_SEQ_BEEP_EN and BEEP_TICKS = 3: after done, beep stays high for 3 ticks then falls. A clear asserted mid-beep drops beep the next cycle.

Source files
------------

// File: rtl/mag_seq_pkg.sv
// Shared types and defaults for the magnetron pulse sequencer.
package mag_seq_pkg;

    localparam int unsigned TIME_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ARMED   = 3'd2,
        ST_COOKING = 3'd3,
        ST_PAUSED  = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/mag_pulse_seq_if.sv
// Command/status bundle between the keypad/timer front end and the cook sequencer.
interface mag_pulse_seq_if
    import mag_seq_pkg::*;
#(
    parameter int unsigned TIME_W = TIME_W_DEF
) ();

    logic              load;
    logic [TIME_W-1:0] load_time;
    logic              start;
    logic              clear;
    logic              door_closed;
    logic              tick;
    logic              S;
    logic              R;
    logic              cooking;
    logic              done;
    logic [TIME_W-1:0] time_left;
    logic              beep;

    // Front end: issues commands, observes latch pulses and status.
    modport master (
        output load, load_time, start, clear, door_closed, tick,
        input  S, R, cooking, done, time_left, beep
    );

    // Sequencer side.
    modport slave (
        input  load, load_time, start, clear, door_closed, tick,
        output S, R, cooking, done, time_left, beep
    );

endinterface

// File: rtl/mag_seq_timer.sv
// Loadable seconds down-counter with tick enable and zero/one flags.
module mag_seq_timer #(
    parameter int unsigned TIME_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [TIME_W-1:0] load_val,
    input  logic              dec_en,
    output logic [TIME_W-1:0] count,
    output logic              is_zero_c,
    output logic              is_one_c
);

    // Load wins over decrement; decrement never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load_en) begin
            count <= load_val;
        end else if (dec_en && !is_zero_c) begin
            count <= count - TIME_W'(1);
        end
    end

    // Flags decoded from the count register.
    assign is_zero_c = (count == '0);
    assign is_one_c  = (count == TIME_W'(1));

endmodule

// File: rtl/mag_pulse_seq.sv
// Cook sequencer producing single-cycle S/R pulses for the magnetron SR latch.
// Optional completion beep enabled with `define MAG_SEQ_BEEP_EN.
module mag_pulse_seq
    import mag_seq_pkg::*;
#(
    parameter int unsigned TIME_W = TIME_W_DEF
`ifdef MAG_SEQ_BEEP_EN
    , parameter int unsigned BEEP_TICKS = 3
`endif
) (
    input logic            clk,
    input logic            rst_n,
    mag_pulse_seq_if.slave bus
);

    state_e            state_q;
    state_e            state_d;
    logic              s_d;
    logic              r_d;
    logic              done_d;
    logic              s_q;
    logic              r_q;
    logic              done_q;
    logic              cooking_q;
    logic              tmr_load;
    logic [TIME_W-1:0] tmr_val;
    logic              tmr_dec;
    logic [TIME_W-1:0] tmr_count;
    logic              tmr_zero;
    logic              tmr_one;

    mag_seq_timer #(
        .TIME_W (TIME_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (tmr_load),
        .load_val  (tmr_val),
        .dec_en    (tmr_dec),
        .count     (tmr_count),
        .is_zero_c (tmr_zero),
        .is_one_c  (tmr_one)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, pulse requests and timer control; clear > door open > load > start > tick.
    always_comb begin
        state_d  = state_q;
        s_d      = 1'b0;
        r_d      = 1'b0;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        if (state_q == ST_INIT) begin
            // Force the latch off once after reset.
            r_d     = 1'b1;
            state_d = ST_IDLE;
        end else if (bus.clear) begin
            tmr_load = 1'b1;
            tmr_val  = '0;
            r_d      = (state_q == ST_COOKING);
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_COOKING: begin
                    if (!bus.door_closed) begin
                        // Door opened: latch off, keep remaining time, drop any tick.
                        r_d     = 1'b1;
                        state_d = ST_PAUSED;
                    end else if (bus.tick) begin
                        if (tmr_one) begin
                            tmr_load = 1'b1;
                            tmr_val  = '0;
                            r_d      = 1'b1;
                            done_d   = 1'b1;
                            state_d  = ST_DONE;
                        end else begin
                            tmr_dec = 1'b1;
                        end
                    end
                end
                ST_IDLE, ST_ARMED, ST_DONE: begin
                    if (bus.load) begin
                        tmr_load = 1'b1;
                        tmr_val  = bus.load_time;
                        state_d  = (bus.load_time != '0) ? ST_ARMED : ST_IDLE;
                    end else if (bus.start && (state_q == ST_ARMED)
                                 && bus.door_closed && !tmr_zero) begin
                        s_d     = 1'b1;
                        state_d = ST_COOKING;
                    end
                end
                ST_PAUSED: begin
                    if (bus.start && bus.door_closed && !tmr_zero) begin
                        s_d     = 1'b1;
                        state_d = ST_COOKING;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Registered pulse and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            done_q    <= 1'b0;
            cooking_q <= 1'b0;
        end else begin
            s_q       <= s_d;
            r_q       <= r_d;
            done_q    <= done_d;
            cooking_q <= (state_d == ST_COOKING);
        end
    end

    assign bus.S         = s_q;
    assign bus.R         = r_q;
    assign bus.done      = done_q;
    assign bus.cooking   = cooking_q;
    assign bus.time_left = tmr_count;

`ifdef MAG_SEQ_BEEP_EN
    localparam int unsigned BEEP_W = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;

    logic              beep_q;
    logic [BEEP_W-1:0] beep_cnt_q;

    // Beep starts with done, lasts BEEP_TICKS ticks; clear/load silence it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else if ((state_q != ST_INIT) && (bus.clear || bus.load)) begin
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else if (done_d) begin
            beep_q     <= 1'b1;
            beep_cnt_q <= BEEP_W'(BEEP_TICKS);
        end else if (beep_q && bus.tick) begin
            beep_cnt_q <= beep_cnt_q - BEEP_W'(1);
            if (beep_cnt_q <= BEEP_W'(1)) begin
                beep_q <= 1'b0;
            end
        end
    end

    assign bus.beep = beep_q;
`else
    assign bus.beep = 1'b0;
`endif

endmodule

// File: tb/tb_mag_pulse_seq.sv
// Directed self-checking bench for mag_pulse_seq.
module tb_mag_pulse_seq;

    localparam int unsigned TW = 8;
`ifdef MAG_SEQ_BEEP_EN
    localparam bit BEEP_EN = 1'b1;
`else
    localparam bit BEEP_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mag_pulse_seq_if #(.TIME_W(TW)) bus ();

    mag_pulse_seq #(.TIME_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the full visible output set.
    task automatic exp_out(input string tag, input logic s, input logic r, input logic c,
                           input logic d, input logic [TW-1:0] t, input logic b);
        chk({tag, ".S"}, 32'(bus.S), 32'(s));
        chk({tag, ".R"}, 32'(bus.R), 32'(r));
        chk({tag, ".cooking"}, 32'(bus.cooking), 32'(c));
        chk({tag, ".done"}, 32'(bus.done), 32'(d));
        chk({tag, ".time_left"}, 32'(bus.time_left), 32'(t));
        chk({tag, ".beep"}, 32'(bus.beep), 32'(b));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.tick  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_in();
        bus.load_time   = '0;
        bus.door_closed = 1'b1;

        // Reset state, then a single INIT R pulse on release.
        cyc(); cyc();
        exp_out("rst", 0, 0, 0, 0, 8'd0, 0);
        rst_n = 1'b1;
        cyc();
        exp_out("init_r", 0, 1, 0, 0, 8'd0, 0);
        cyc();
        exp_out("idle", 0, 0, 0, 0, 8'd0, 0);

        // Load 3 and cook to completion.
        bus.load = 1'b1; bus.load_time = 8'd3;
        cyc(); idle_in();
        exp_out("load3", 0, 0, 0, 0, 8'd3, 0);
        bus.start = 1'b1;
        cyc(); idle_in();
        exp_out("start3", 1, 0, 1, 0, 8'd3, 0);
        cyc();
        exp_out("cook3", 0, 0, 1, 0, 8'd3, 0);
        bus.tick = 1'b1;
        cyc(); idle_in();
        exp_out("tick_a", 0, 0, 1, 0, 8'd2, 0);
        cyc();
        exp_out("no_tick", 0, 0, 1, 0, 8'd2, 0);
        bus.tick = 1'b1;
        cyc(); idle_in();
        exp_out("tick_b", 0, 0, 1, 0, 8'd1, 0);
        bus.tick = 1'b1;
        cyc(); idle_in();
        exp_out("expire", 0, 1, 0, 1, 8'd0, BEEP_EN);
        cyc();
        exp_out("done_hold", 0, 0, 0, 0, 8'd0, BEEP_EN);

        // Beep lasts three ticks (when built in); ticks in DONE leave time alone.
        bus.tick = 1'b1;
        cyc(); idle_in();
        exp_out("beep_t1", 0, 0, 0, 0, 8'd0, BEEP_EN);
        bus.tick = 1'b1;
        cyc(); idle_in();
        exp_out("beep_t2", 0, 0, 0, 0, 8'd0, BEEP_EN);
        bus.tick = 1'b1;
        cyc(); idle_in();
        exp_out("beep_t3", 0, 0, 0, 0, 8'd0, 0);

        // start in DONE with zero time is ignored.
        bus.start = 1'b1;
        cyc(); idle_in();
        exp_out("start_done", 0, 0, 0, 0, 8'd0, 0);

        // load 0 goes to IDLE; start there is ignored.
        bus.load = 1'b1; bus.load_time = 8'd0;
        cyc(); idle_in();
        bus.start = 1'b1;
        cyc(); idle_in();
        exp_out("start_idle", 0, 0, 0, 0, 8'd0, 0);

        // ARMED with door open: start ignored; tick outside COOKING ignored.
        bus.load = 1'b1; bus.load_time = 8'd7;
        cyc(); idle_in();
        exp_out("load7", 0, 0, 0, 0, 8'd7, 0);
        bus.door_closed = 1'b0;
        bus.start = 1'b1;
        cyc(); idle_in();
        exp_out("start_door_open", 0, 0, 0, 0, 8'd7, 0);
        bus.tick = 1'b1;
        cyc(); idle_in();
        exp_out("tick_armed", 0, 0, 0, 0, 8'd7, 0);
        bus.door_closed = 1'b1;

        // Door opens together with a tick: pause at 5, then resume.
        bus.load = 1'b1; bus.load_time = 8'd5;
        cyc(); idle_in();
        bus.start = 1'b1;
        cyc(); idle_in();
        exp_out("start5", 1, 0, 1, 0, 8'd5, 0);
        bus.door_closed = 1'b0; bus.tick = 1'b1;
        cyc(); idle_in();
        exp_out("door_open", 0, 1, 0, 0, 8'd5, 0);
        cyc();
        exp_out("paused", 0, 0, 0, 0, 8'd5, 0);
        bus.door_closed = 1'b1; bus.start = 1'b1;
        cyc(); idle_in();
        exp_out("resume", 1, 0, 1, 0, 8'd5, 0);
        bus.tick = 1'b1;
        cyc(); idle_in();
        exp_out("tick_resume", 0, 0, 1, 0, 8'd4, 0);

        // clear + start together while cooking at 4.
        bus.clear = 1'b1; bus.start = 1'b1;
        cyc(); idle_in();
        exp_out("clear_cook", 0, 1, 0, 0, 8'd0, 0);
        cyc();
        exp_out("clear_after", 0, 0, 0, 0, 8'd0, 0);

        // load during COOKING is ignored.
        bus.load = 1'b1; bus.load_time = 8'd6;
        cyc(); idle_in();
        bus.start = 1'b1;
        cyc(); idle_in();
        exp_out("start6", 1, 0, 1, 0, 8'd6, 0);
        bus.load = 1'b1; bus.load_time = 8'd9;
        cyc(); idle_in();
        exp_out("load_in_cook", 0, 0, 1, 0, 8'd6, 0);
        bus.clear = 1'b1;
        cyc(); idle_in();
        exp_out("clear6", 0, 1, 0, 0, 8'd0, 0);

        // Clear while beeping silences the beep on the next cycle.
        bus.load = 1'b1; bus.load_time = 8'd1;
        cyc(); idle_in();
        bus.start = 1'b1;
        cyc(); idle_in();
        bus.tick = 1'b1;
        cyc(); idle_in();
        exp_out("expire1", 0, 1, 0, 1, 8'd0, BEEP_EN);
        bus.tick = 1'b1;
        cyc(); idle_in();
        exp_out("beep_mid", 0, 0, 0, 0, 8'd0, BEEP_EN);
        bus.clear = 1'b1;
        cyc(); idle_in();
        exp_out("beep_clear", 0, 0, 0, 0, 8'd0, 0);

        // Asynchronous reset mid-cook, then INIT R pulse on release.
        bus.load = 1'b1; bus.load_time = 8'd2;
        cyc(); idle_in();
        bus.start = 1'b1;
        cyc(); idle_in();
        exp_out("start2", 1, 0, 1, 0, 8'd2, 0);
        #3;
        rst_n = 1'b0;
        #1;
        exp_out("async_rst", 0, 0, 0, 0, 8'd0, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        exp_out("init_r2", 0, 1, 0, 0, 8'd0, 0);
        cyc();
        exp_out("idle2", 0, 0, 0, 0, 8'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time guard.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
